bus_arbiter_rr: RTL and testbench

Round-robin arbiter that shares the single system bus between up to 32 bus masters, such as the DMA custom-instruction block and the CPU instruction/data ports. It answers each master's `requestTransaction` with a one-cycle `transactionGranted` pulse, then tracks the granted burst until the bus signals end of transaction. A watchdog force-terminates a hung burst so the bus is never deadlocked.

---
 rtl/bus_arbiter_rr.sv | 154 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: one-cycle grant pulse, begin-timeout recovery and
// an idle-burst watchdog that forces end-of-transaction with a bus error.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS     = 4,
    parameter int BEGIN_TIMEOUT   = 4,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] requests,
    output logic [NUM_MASTERS-1:0] grants,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    input  logic                   dataValidIn,
    input  logic                   busErrorIn,
    output logic                   endTransactionOut,
    output logic                   busErrorOut,
    output logic                   busIdle,
    output logic [4:0]             activeMaster,
    output logic                   timeoutFlag
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT_BEGIN,
        S_ACTIVE,
        S_FORCE_END
    } state_t;

    localparam logic [15:0] BT_LAST = 16'(BEGIN_TIMEOUT - 1);
    localparam logic [15:0] WD_LAST = 16'(WATCHDOG_CYCLES - 1);
    localparam logic [4:0]  LAST_M  = 5'(NUM_MASTERS - 1);

    state_t                 state_q, state_d;
    logic [4:0]             rr_ptr_q, rr_ptr_d;
    logic [15:0]            begin_cnt_q, begin_cnt_d;
    logic [15:0]            wd_q, wd_d;
    logic [NUM_MASTERS-1:0] grants_q, grants_d;
    logic                   end_out_q, end_out_d;
    logic                   bus_err_q, bus_err_d;
    logic                   bus_idle_q, bus_idle_d;
    logic [4:0]             active_master_q, active_master_d;
    logic                   timeout_q, timeout_d;

    logic [4:0] winner;
    logic       found;

    // Two-pass search: first from the pointer upward, then wrap from bit 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!found && requests[j] && (5'(j) >= rr_ptr_q)) begin
                found  = 1'b1;
                winner = 5'(j);
            end
        end
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!found && requests[j]) begin
                found  = 1'b1;
                winner = 5'(j);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        begin_cnt_d     = begin_cnt_q;
        wd_d            = wd_q;
        active_master_d = active_master_q;
        timeout_d       = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d         = S_GRANT;
                    active_master_d = winner;
                end
            end
            S_GRANT: begin
                state_d     = S_WAIT_BEGIN;
                begin_cnt_d = '0;
                rr_ptr_d    = (active_master_q == LAST_M) ? 5'd0 : active_master_q + 5'd1;
            end
            S_WAIT_BEGIN: begin
                if (beginTransactionIn && endTransactionIn) begin
                    state_d = S_IDLE;
                end else if (beginTransactionIn) begin
                    state_d = S_ACTIVE;
                    wd_d    = '0;
                end else if (begin_cnt_q == BT_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    begin_cnt_d = begin_cnt_q + 16'd1;
                end
            end
            S_ACTIVE: begin
                // Activity in the last allowed cycle still rescues the burst.
                if (endTransactionIn) begin
                    state_d = S_IDLE;
                end else if (dataValidIn || busErrorIn) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d   = S_FORCE_END;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
                end
            end
            S_FORCE_END: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        for (int i = 0; i < NUM_MASTERS; i++)
            grants_d[i] = (state_d == S_GRANT) && (active_master_d == 5'(i));
        end_out_d  = (state_d == S_FORCE_END);
        bus_err_d  = (state_d == S_FORCE_END);
        bus_idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            rr_ptr_q        <= '0;
            begin_cnt_q     <= '0;
            wd_q            <= '0;
            grants_q        <= '0;
            end_out_q       <= 1'b0;
            bus_err_q       <= 1'b0;
            bus_idle_q      <= 1'b1;
            active_master_q <= '0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            begin_cnt_q     <= begin_cnt_d;
            wd_q            <= wd_d;
            grants_q        <= grants_d;
            end_out_q       <= end_out_d;
            bus_err_q       <= bus_err_d;
            bus_idle_q      <= bus_idle_d;
            active_master_q <= active_master_d;
            timeout_q       <= timeout_d;
        end
    end

    assign grants            = grants_q;
    assign endTransactionOut = end_out_q;
    assign busErrorOut       = bus_err_q;
    assign busIdle           = bus_idle_q;
    assign activeMaster      = active_master_q;
    assign timeoutFlag       = timeout_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: grant-order table, multi-cycle corner sequences and
// randomized bursts checked against a transaction-level round-robin model.
module tb_bus_arbiter_rr;
    localparam int N  = 4;
    localparam int BT = 4;
    localparam int WD = 1024;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] requests = '0;
    logic         begin_in = 1'b0, end_in = 1'b0, dv_in = 1'b0, berr_in = 1'b0;
    logic [N-1:0] grants;
    logic         end_out, berr_out, bus_idle, timeout_flag;
    logic [4:0]   active_master;

    bus_arbiter_rr #(.NUM_MASTERS(N), .BEGIN_TIMEOUT(BT), .WATCHDOG_CYCLES(WD)) dut (
        .clock(clock), .reset(reset), .requests(requests), .grants(grants),
        .beginTransactionIn(begin_in), .endTransactionIn(end_in),
        .dataValidIn(dv_in), .busErrorIn(berr_in),
        .endTransactionOut(end_out), .busErrorOut(berr_out), .busIdle(bus_idle),
        .activeMaster(active_master), .timeoutFlag(timeout_flag)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int rr_m     = 0;    // model: next master with top priority
    bit flag_m   = 1'b0; // model: sticky timeout

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp_grant;
        int           exp_idx;
        int           beats;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int m;
            m = (ptr + k) % N;
            if (r[m]) return m;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1; requests = '0;
        begin_in = 0; end_in = 0; dv_in = 0; berr_in = 0;
        tick(); tick();
        reset = 1'b0;
        rr_m = 0; flag_m = 1'b0;
    endtask

    // Full burst: grant, begin in first WAIT_BEGIN cycle, beats of data, end.
    task automatic burst(input logic [N-1:0] req, input logic [N-1:0] exp_g, input int exp_i, input int beats);
        int low;
        requests = req;
        tick();
        check("grant", grants, exp_g);
        check("active_master", active_master, exp_i);
        low = bus_idle ? 0 : 1;
        tick();
        check("grant_one_cycle", grants, 0);
        low += bus_idle ? 0 : 1;
        begin_in = 1; tick(); begin_in = 0;
        low += bus_idle ? 0 : 1;
        for (int b = 0; b < beats; b++) begin
            dv_in = 1; tick(); dv_in = 0;
            low += bus_idle ? 0 : 1;
        end
        end_in = 1; tick(); end_in = 0;
        check("idle_after_end", bus_idle, 1);
        check("busy_cycles", low, beats + 3);
        check("no_grant_turnaround", grants, 0);
        rr_m = (exp_i + 1) % N;
    endtask

    task automatic wait_idle(input int bound, output int cnt, output bit saw_end);
        cnt = 0; saw_end = 0;
        while (cnt < bound) begin
            tick(); cnt++;
            if (end_out) saw_end = 1;
            if (bus_idle) break;
        end
    endtask

    task automatic enter_active(input logic [N-1:0] req);
        int w;
        w = pick(req, rr_m);
        requests = req; tick(); requests = '0;
        check("wd_grant", grants, 32'(1) << w);
        rr_m = (w + 1) % N;
        tick();
        begin_in = 1; tick(); begin_in = 0;
    endtask

    task automatic wait_force(output int cnt);
        cnt = 0;
        while (cnt < WD + 50 && !end_out) begin
            tick(); cnt++;
        end
    endtask

    initial begin
        int cnt, w, sc, d, nb;
        bit saw_end;
        logic [N-1:0] r;

        tbl[0]  = '{4'b0001, 4'b0001, 0, 3};
        tbl[1]  = '{4'b1111, 4'b0010, 1, 1};
        tbl[2]  = '{4'b1010, 4'b1000, 3, 2};
        tbl[3]  = '{4'b1010, 4'b0010, 1, 0};
        tbl[4]  = '{4'b0100, 4'b0100, 2, 1};
        tbl[5]  = '{4'b0001, 4'b0001, 0, 2};
        tbl[6]  = '{4'b1111, 4'b0010, 1, 1};
        tbl[7]  = '{4'b1111, 4'b0100, 2, 1};
        tbl[8]  = '{4'b1111, 4'b1000, 3, 1};
        tbl[9]  = '{4'b1111, 4'b0001, 0, 1};
        tbl[10] = '{4'b1100, 4'b0100, 2, 4};

        do_reset();
        check("rst_grants", grants, 0);
        check("rst_idle", bus_idle, 1);
        check("rst_master", active_master, 0);
        check("rst_flag", timeout_flag, 0);
        check("rst_end_out", end_out, 0);
        check("rst_berr_out", berr_out, 0);

        foreach (tbl[i]) burst(tbl[i].req, tbl[i].exp_grant, tbl[i].exp_idx, tbl[i].beats);
        requests = '0;

        // Begin timeout: no begin after the grant.
        w = pick(4'b0100, rr_m);
        requests = 4'b0100; tick(); requests = '0;
        check("to_grant", grants, 32'(1) << w);
        rr_m = (w + 1) % N;
        wait_idle(20, cnt, saw_end);
        check("to_cycles", cnt, 1 + BT);
        check("to_no_force", saw_end, 0);
        check("to_flag", timeout_flag, 1);

        // Watchdog with a fully quiet burst.
        do_reset();
        check("wd_flag_cleared", timeout_flag, 0);
        enter_active(4'b0001);
        wait_force(cnt);
        check("wd_quiet_cycles", cnt, WD);
        check("wd_berr_out", berr_out, 1);
        tick();
        check("wd_end_pulse", end_out, 0);
        check("wd_berr_pulse", berr_out, 0);
        check("wd_idle", bus_idle, 1);
        check("wd_flag", timeout_flag, 1);

        // Watchdog rearmed by a data beat at cycle 1000.
        do_reset();
        enter_active(4'b0010);
        saw_end = 0;
        repeat (999) begin tick(); if (end_out) saw_end = 1; end
        dv_in = 1; tick(); dv_in = 0;
        if (end_out) saw_end = 1;
        check("wd_no_early_force", saw_end, 0);
        wait_force(cnt);
        check("wd_rearm_cycles", cnt, WD);
        tick();
        check("wd_rearm_flag", timeout_flag, 1);

        // Reset mid-burst with the pointer away from 0 and the flag set.
        enter_active(4'b0100);
        dv_in = 1; tick(); dv_in = 0;
        reset = 1; tick(); reset = 0;
        check("mid_rst_idle", bus_idle, 1);
        check("mid_rst_grants", grants, 0);
        check("mid_rst_flag", timeout_flag, 0);
        check("mid_rst_end_out", end_out, 0);
        check("mid_rst_master", active_master, 0);
        rr_m = 0; flag_m = 0;
        requests = 4'b1111; tick(); requests = '0;
        check("mid_rst_priority", grants, 4'b0001);
        rr_m = 1;
        wait_idle(20, cnt, saw_end);
        flag_m = 1;

        // Randomized bursts against the transaction-level model.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            w = pick(r, rr_m);
            requests = r; tick();
            check("rnd_grant", grants, 32'(1) << w);
            check("rnd_master", active_master, w);
            rr_m = (w + 1) % N;
            requests = N'($urandom);
            sc = $urandom_range(0, 3);
            if (sc == 3) begin
                wait_idle(20, cnt, saw_end);
                check("rnd_to_cycles", cnt, 1 + BT);
                check("rnd_to_no_force", saw_end, 0);
                flag_m = 1;
            end else begin
                tick();
                d = $urandom_range(0, BT - 1);
                repeat (d) tick();
                check("rnd_wait_busy", bus_idle, 0);
                begin_in = 1;
                if (sc == 2) end_in = 1;
                tick();
                begin_in = 0; end_in = 0;
                if (sc != 2) begin
                    nb = $urandom_range(0, 6);
                    for (int b = 0; b < nb; b++) begin
                        dv_in = $urandom_range(0, 1);
                        berr_in = ($urandom_range(0, 7) == 0);
                        tick();
                    end
                    dv_in = 0;
                    check("rnd_active_busy", bus_idle, 0);
                    end_in = 1; berr_in = $urandom_range(0, 1);
                    tick();
                    end_in = 0; berr_in = 0;
                end
                check("rnd_end_idle", bus_idle, 1);
            end
            check("rnd_flag", timeout_flag, flag_m);
        end
        requests = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
